// File: rtl/dm163_pkg.sv
// Shared constants and scan FSM encoding for the DM163 Colorshield pixel grid.
package dm163_pkg;

    localparam int unsigned BITS_PER_PIXEL = 24;
    localparam int unsigned PIXELS_PER_COL = 8;
    localparam int unsigned N_COLS         = 8;
    localparam int unsigned N_BITS         = BITS_PER_PIXEL * PIXELS_PER_COL;
    localparam int unsigned COL_W          = $clog2(N_COLS);
    localparam int unsigned BITCNT_W       = $clog2(N_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_e;

    // One-hot column enable for a column index.
    function automatic logic [N_COLS-1:0] col_onehot(input logic [COL_W-1:0] idx);
        return N_COLS'(1) << idx;
    endfunction

endpackage

// File: rtl/dm163_serializer.sv
// Shifts a 192-bit column word MSB-first onto SDA with a divided SCK.
// A load pulse snapshots the word; o_done is high on the final shift cycle.
module dm163_serializer
    import dm163_pkg::*;
#(
    parameter int unsigned SCK_DIV = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_data,
    output logic              o_done,
    output logic              o_sck,
    output logic              o_sda
);

    localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [N_BITS-1:0]   r_shreg;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic [DIV_W-1:0]    r_div;
    logic                r_high;
    logic                r_busy;

    logic w_phase_end;
    logic w_last;

    assign w_phase_end = (r_div == DIV_W'(SCK_DIV - 1));
    assign w_last      = r_busy & r_high & w_phase_end & (r_bitcnt == BITCNT_W'(1));

    // Snapshot on load, then alternate low/high SCK phases, shifting after each high phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_high   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_load) begin
            r_shreg  <= i_data;
            r_bitcnt <= BITCNT_W'(N_BITS);
            r_div    <= '0;
            r_high   <= 1'b0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (w_phase_end) begin
                r_div <= '0;
                if (r_high) begin
                    r_high   <= 1'b0;
                    r_shreg  <= {r_shreg[N_BITS-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - BITCNT_W'(1);
                    if (r_bitcnt == BITCNT_W'(1)) begin
                        r_busy <= 1'b0;
                    end
                end else begin
                    r_high <= 1'b1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Pins are forced low whenever no word is being shifted.
    assign o_sck  = r_busy & r_high;
    assign o_sda  = r_busy & r_shreg[N_BITS-1];
    assign o_done = w_last;

endmodule

// File: rtl/dm163_column_scanner.sv
// Column scanner: fetches each grid column, shifts it into the DM163,
// latches it, then enables that column for a fixed display time.
module dm163_column_scanner
    import dm163_pkg::*;
#(
    parameter int unsigned SCK_DIV    = 2,
    parameter int unsigned LAT_CYCLES = 2,
    parameter int unsigned ON_CYCLES  = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_BITS-1:0] col_bits,
    output logic [COL_W-1:0]  col_idx,
    output logic              sda,
    output logic              sck,
    output logic              lat,
    output logic [N_COLS-1:0] channel,
    output logic              frame_done
);

    localparam int unsigned CNT_MAX = (ON_CYCLES > LAT_CYCLES) ? ON_CYCLES : LAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_e      r_state;
    scan_state_e      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [COL_W-1:0] r_col_idx;
    logic             r_frame_done;

    logic w_load;
    logic w_ser_done;
    logic w_ser_sck;
    logic w_ser_sda;
    logic w_lat_end;
    logic w_on_end;

    assign w_lat_end = (r_cnt == CNT_W'(LAT_CYCLES - 1));
    assign w_on_end  = (r_cnt == CNT_W'(ON_CYCLES - 1));

    dm163_serializer #(
        .SCK_DIV (SCK_DIV)
    ) u_serializer (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_data  (col_bits),
        .o_done  (w_ser_done),
        .o_sck   (w_ser_sck),
        .o_sda   (w_ser_sda)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, serializer load strobe, latch and column-enable decode.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        lat     = 1'b0;
        channel = '0;
        unique case (r_state)
            IDLE: begin
                if (enable) w_next = LOAD;
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                if (w_ser_done) w_next = LATCH;
            end
            LATCH: begin
                lat = 1'b1;
                if (w_lat_end) w_next = DISPLAY;
            end
            DISPLAY: begin
                channel = col_onehot(r_col_idx);
                if (w_on_end) w_next = enable ? LOAD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Shared LATCH/DISPLAY duration counter; only one of the two phases is active at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == LATCH && !w_lat_end) || (r_state == DISPLAY && !w_on_end)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Column advance on the last display cycle; frame pulse after column 7 wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == DISPLAY && w_on_end) begin
                r_col_idx    <= r_col_idx + COL_W'(1);
                r_frame_done <= (r_col_idx == COL_W'(N_COLS - 1));
            end
        end
    end

    assign col_idx    = r_col_idx;
    assign frame_done = r_frame_done;
    assign sck        = w_ser_sck;
    assign sda        = w_ser_sda;

endmodule

// File: tb/tb_dm163_column_scanner.sv
// Bench for dm163_column_scanner: a default-parameter instance fed by a grid
// model, and a fast instance (SCK_DIV=1) with directly driven column words.
module tb_dm163_column_scanner;

    localparam int CP  = 2771;
    localparam int ON0 = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         enable0, enable1;
    logic [191:0] col_bits0, col_bits1;
    logic [2:0]   col_idx0, col_idx1;
    logic         sda0, sck0, lat0, fd0;
    logic         sda1, sck1, lat1, fd1;
    logic [7:0]   ch0, ch1;

    int n_tests = 0;
    int n_fail  = 0;

    bit q0[$];
    bit q1[$];

    dm163_column_scanner #(
        .SCK_DIV    (2),
        .LAT_CYCLES (2),
        .ON_CYCLES  (2000)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable0),
        .col_bits   (col_bits0),
        .col_idx    (col_idx0),
        .sda        (sda0),
        .sck        (sck0),
        .lat        (lat0),
        .channel    (ch0),
        .frame_done (fd0)
    );

    dm163_column_scanner #(
        .SCK_DIV    (1),
        .LAT_CYCLES (1),
        .ON_CYCLES  (4)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable1),
        .col_bits   (col_bits1),
        .col_idx    (col_idx1),
        .sda        (sda1),
        .sck        (sck1),
        .lat        (lat1),
        .channel    (ch1),
        .frame_done (fd1)
    );

    // Grid model: column c holds FF0000 in the top pixel and c in the low bits.
    function automatic logic [191:0] grid_word(input logic [2:0] c);
        logic [191:0] w;
        w = '0;
        w[191:168] = 24'hFF0000;
        w[2:0] = c;
        return w;
    endfunction

    always_comb col_bits0 = grid_word(col_idx0);

    task automatic push_word0(input logic [191:0] w);
        for (int i = 191; i >= 0; i--) q0.push_back(w[i]);
    endtask

    task automatic push_word1(input logic [191:0] w);
        for (int i = 191; i >= 0; i--) q1.push_back(w[i]);
    endtask

    // Scoreboard consumers and pin-protocol invariants, sampled on the falling clock edge.
    logic p_sck0 = 1'b0, p_sda0 = 1'b0, p_sck1 = 1'b0, p_sda1 = 1'b0;

    always @(negedge clk) begin
        bit e;
        if (sck0 && !p_sck0) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_sda_unexpected: sck rise with empty scoreboard, sda=%0b", sda0);
            end else begin
                e = q0.pop_front();
                if (sda0 !== e) begin
                    n_fail++;
                    $display("FAIL dut0_sda_bit: got %0b expected %0b (%0d bits left)", sda0, e, q0.size());
                end
            end
        end
        if (sck0 && lat0) begin
            n_fail++;
            $display("FAIL dut0_sck_lat_overlap: sck=%0b lat=%0b expected not both", sck0, lat0);
        end
        if (p_sck0 && sck0 && (sda0 !== p_sda0)) begin
            n_fail++;
            $display("FAIL dut0_sda_while_sck_high: got %0b expected %0b", sda0, p_sda0);
        end
        if ((ch0 !== 8'h00) && (sck0 || lat0)) begin
            n_fail++;
            $display("FAIL dut0_blanking: channel=%02h with sck=%0b lat=%0b", ch0, sck0, lat0);
        end
        p_sck0 = sck0;
        p_sda0 = sda0;
    end

    always @(negedge clk) begin
        bit e;
        if (sck1 && !p_sck1) begin
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_sda_unexpected: sck rise with empty scoreboard, sda=%0b", sda1);
            end else begin
                e = q1.pop_front();
                if (sda1 !== e) begin
                    n_fail++;
                    $display("FAIL dut1_sda_bit: got %0b expected %0b (%0d bits left)", sda1, e, q1.size());
                end
            end
        end
        if (sck1 && lat1) begin
            n_fail++;
            $display("FAIL dut1_sck_lat_overlap: sck=%0b lat=%0b expected not both", sck1, lat1);
        end
        if (p_sck1 && sck1 && (sda1 !== p_sda1)) begin
            n_fail++;
            $display("FAIL dut1_sda_while_sck_high: got %0b expected %0b", sda1, p_sda1);
        end
        p_sck1 = sck1;
        p_sda1 = sda1;
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        enable0   = 1'b0;
        enable1   = 1'b0;
        col_bits1 = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({sda0, sck0, lat0, ch0, fd0, col_idx0} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: got sda=%0b sck=%0b lat=%0b ch=%02h fd=%0b col=%0d expected all 0",
                     sda0, sck0, lat0, ch0, fd0, col_idx0);
        end
        n_tests++;
        if ({sda1, sck1, lat1, ch1, fd1, col_idx1} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: got sda=%0b sck=%0b lat=%0b ch=%02h fd=%0b col=%0d expected all 0",
                     sda1, sck1, lat1, ch1, fd1, col_idx1);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({sda0, sck0, lat0, ch0, fd0, col_idx0} !== 15'h0) begin
            n_fail++;
            $display("FAIL idle_hold: got sda=%0b sck=%0b lat=%0b ch=%02h col=%0d expected all 0 with enable=0",
                     sda0, sck0, lat0, ch0, col_idx0);
        end
    endtask

    task automatic test_pattern_div1();
        logic [191:0] w;
        int t, rises, first_r, last_r;
        logic ps;
        w = {24{8'hA5}};
        col_bits1 = w;
        push_word1(w);
        enable1 = 1'b1;
        rises = 0; first_r = -1; last_r = -1; ps = sck1;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            if (sck1 && !ps) begin
                rises++;
                if (first_r < 0) first_r = t;
                last_r = t;
            end
            ps = sck1;
            if (ch1 != 8'h00) break;
        end
        n_tests++;
        if (ch1 !== 8'h01 || t != 386) begin
            n_fail++;
            $display("FAIL div1_display_start: got ch=%02h at cycle %0d expected 01 at 386", ch1, t);
        end
        n_tests++;
        if (rises != 192) begin
            n_fail++;
            $display("FAIL div1_sck_rises: got %0d expected 192", rises);
        end
        n_tests++;
        if (last_r - first_r != 382) begin
            n_fail++;
            $display("FAIL div1_sck_period: got span %0d expected 382", last_r - first_r);
        end
        n_tests++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL div1_stream_len: got %0d bits unshifted expected 0", q1.size());
        end
    endtask

    task automatic test_snapshot();
        logic [191:0] p;
        int t;
        bit ok;
        logic ps;
        p = {12{16'h3C96}};
        col_bits1 = p;
        push_word1(p);
        ps = sck1; ok = 1'b0;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sck1 && !ps) begin ok = 1'b1; break; end
            ps = sck1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL snap_shift_timeout: got no sck rise expected one within 100 cycles");
        end
        col_bits1 = ~p;
        enable1 = 1'b0;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            if (ch1 != 8'h00) break;
        end
        n_tests++;
        if (ch1 !== 8'h02) begin
            n_fail++;
            $display("FAIL snap_channel: got %02h expected 02", ch1);
        end
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ch1 == 8'h00) break;
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if ({sda1, sck1, lat1, ch1, col_idx1} !== {3'b000, 8'h00, 3'd2}) begin
            n_fail++;
            $display("FAIL snap_idle: got sda=%0b sck=%0b lat=%0b ch=%02h col=%0d expected 0,0,0,00,2",
                     sda1, sck1, lat1, ch1, col_idx1);
        end
        n_tests++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL snap_stream_len: got %0d bits unshifted expected 0", q1.size());
        end
    endtask

    task automatic test_first_column();
        int t, rises, last_fall, lat_first, lat_len, ch_len;
        logic ps;
        push_word0(grid_word(3'd0));
        enable0 = 1'b1;
        rises = 0; last_fall = -1; lat_first = -1; lat_len = 0; ch_len = 0; ps = sck0;
        for (t = 0; t < CP + 20; t++) begin
            @(negedge clk);
            if (sck0 && !ps) rises++;
            if (!sck0 && ps) last_fall = t;
            if (lat0) begin
                if (lat_first < 0) lat_first = t;
                lat_len++;
            end
            if (ch0 == 8'h01) ch_len++;
            if (ch_len > 0 && ch0 != 8'h01) break;
            ps = sck0;
        end
        n_tests++;
        if (rises != 192) begin
            n_fail++;
            $display("FAIL col0_sck_rises: got %0d expected 192", rises);
        end
        n_tests++;
        if (lat_len != 2 || lat_first != last_fall || lat_first != 769) begin
            n_fail++;
            $display("FAIL col0_latch: got len %0d start %0d (last sck fall %0d) expected len 2 start 769",
                     lat_len, lat_first, last_fall);
        end
        n_tests++;
        if (ch_len != ON0) begin
            n_fail++;
            $display("FAIL col0_display_len: got %0d expected %0d", ch_len, ON0);
        end
        n_tests++;
        if (t != CP || ch0 !== 8'h00) begin
            n_fail++;
            $display("FAIL col0_period: got end at %0d ch=%02h expected %0d ch=00", t, ch0, CP);
        end
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL col0_stream_len: got %0d bits unshifted expected 0", q0.size());
        end
    endtask

    task automatic test_free_run();
        int t, nrise, last_rise, nfd;
        logic [7:0] prev_ch, exp_ch;
        logic [2:0] exp_col;
        for (int c = 1; c <= 8; c++) push_word0(grid_word(3'(c % 8)));
        prev_ch = 8'h00; nrise = 0; nfd = 0; last_rise = 0; exp_col = 3'd1;
        for (t = 1; t <= 8 * CP + 20; t++) begin
            @(negedge clk);
            if (fd0) begin
                nfd++;
                n_tests++;
                if (prev_ch !== 8'h80 || col_idx0 !== 3'd0) begin
                    n_fail++;
                    $display("FAIL frame_done_pos: got prev ch=%02h col=%0d expected 80 and 0", prev_ch, col_idx0);
                end
            end
            if (ch0 != 8'h00 && prev_ch == 8'h00) begin
                exp_ch = 8'b1 << exp_col;
                n_tests++;
                if (ch0 !== exp_ch || col_idx0 !== exp_col) begin
                    n_fail++;
                    $display("FAIL walk_channel: got ch=%02h col=%0d expected ch=%02h col=%0d",
                             ch0, col_idx0, exp_ch, exp_col);
                end
                if (nrise > 0) begin
                    n_tests++;
                    if (t - last_rise != CP) begin
                        n_fail++;
                        $display("FAIL walk_period: got %0d expected %0d", t - last_rise, CP);
                    end
                end
                last_rise = t;
                nrise++;
                exp_col = exp_col + 3'd1;
            end
            if (ch0 == 8'h00 && prev_ch != 8'h00 && nrise == 8) break;
            prev_ch = ch0;
        end
        n_tests++;
        if (nrise != 8 || t != 8 * CP) begin
            n_fail++;
            $display("FAIL walk_frame: got %0d columns in %0d cycles expected 8 in %0d", nrise, t, 8 * CP);
        end
        n_tests++;
        if (nfd != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d expected 1", nfd);
        end
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL walk_stream_len: got %0d bits unshifted expected 0", q0.size());
        end
    endtask

    task automatic test_disable_mid_shift();
        int t, len, bad;
        bit ok;
        push_word0(grid_word(3'd1));
        push_word0(grid_word(3'd2));
        push_word0(grid_word(3'd3));
        ok = 1'b0;
        for (t = 0; t < 3 * CP + 100; t++) begin
            @(negedge clk);
            if (col_idx0 == 3'd3 && sck0) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dis_col3_timeout: got no column-3 shift expected one within %0d cycles", 3 * CP + 100);
        end
        enable0 = 1'b0;
        for (t = 0; t < CP; t++) begin
            @(negedge clk);
            if (ch0 != 8'h00) break;
        end
        n_tests++;
        if (ch0 !== 8'h08) begin
            n_fail++;
            $display("FAIL dis_channel: got %02h expected 08", ch0);
        end
        len = 0;
        for (t = 0; t < ON0 + 20; t++) begin
            if (ch0 == 8'h00) break;
            len++;
            @(negedge clk);
        end
        n_tests++;
        if (len != ON0) begin
            n_fail++;
            $display("FAIL dis_display_len: got %0d expected %0d", len, ON0);
        end
        bad = 0;
        repeat (10) begin
            if ({sda0, sck0, lat0, ch0, fd0} !== 12'h0 || col_idx0 !== 3'd4) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dis_idle: got %0d bad cycles (col=%0d ch=%02h) expected 0 with col=4", bad, col_idx0, ch0);
        end
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL dis_stream_len: got %0d bits unshifted expected 0", q0.size());
        end
        push_word0(grid_word(3'd4));
        enable0 = 1'b1;
        for (t = 0; t < CP + 20; t++) begin
            @(negedge clk);
            if (ch0 != 8'h00) break;
        end
        n_tests++;
        if (ch0 !== 8'h10) begin
            n_fail++;
            $display("FAIL reenable_channel: got %02h expected 10", ch0);
        end
    endtask

    task automatic test_reset_mid_shift();
        int t;
        bit ok;
        push_word0(grid_word(3'd5));
        ok = 1'b0;
        for (t = 0; t < 2 * CP; t++) begin
            @(negedge clk);
            if (col_idx0 == 3'd5 && sck0) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok || sda0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: got shift=%0b sda=%0b expected 1 and 1", ok, sda0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sck0, sda0, lat0, ch0} !== 11'h0) begin
            n_fail++;
            $display("FAIL rst_async_pins: got sck=%0b sda=%0b lat=%0b ch=%02h expected all 0", sck0, sda0, lat0, ch0);
        end
        n_tests++;
        if (col_idx0 !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_async_col: got %0d expected 0", col_idx0);
        end
        q0.delete();
        repeat (2) @(negedge clk);
        push_word0(grid_word(3'd0));
        rst_n = 1'b1;
        for (t = 0; t < CP + 20; t++) begin
            @(negedge clk);
            if (t == 0) enable0 = 1'b0;
            if (ch0 != 8'h00) break;
        end
        n_tests++;
        if (ch0 !== 8'h01 || col_idx0 !== 3'd0 || t != 771) begin
            n_fail++;
            $display("FAIL rst_restart: got ch=%02h col=%0d at cycle %0d expected 01, 0, 771", ch0, col_idx0, t);
        end
        for (t = 0; t < ON0 + 20; t++) begin
            @(negedge clk);
            if (ch0 == 8'h00) break;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (q0.size() != 0 || col_idx0 !== 3'd1 || ch0 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_restart_end: got %0d bits left col=%0d ch=%02h expected 0, 1, 00",
                     q0.size(), col_idx0, ch0);
        end
    endtask

    initial begin
        test_reset();
        test_pattern_div1();
        test_snapshot();
        test_first_column();
        test_free_run();
        test_disable_mid_shift();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm163_column_scanner.md
Name: dm163_column_scanner

Overview:
- Read side of the pixel grid: walks columns 0..7, reads the 192-bit column word from the grid, and shifts it serially into the DM163 on the Colorshield.
- Drives SDA/SCK/LAT, then turns on the matching column enable for a fixed display time.
- Sits between the grid's column read port (col_idx/col_bits) and the shield pins; free-runs while enable=1.

Parameters:
- SCK_DIV, 2, clk cycles per SCK half-period (>=1).
- LAT_CYCLES, 2, clk cycles LAT is held high (>=1).
- ON_CYCLES, 2000, clk cycles a column stays enabled (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- enable  in  1  run scanning; sampled only in IDLE and at end of DISPLAY
- col_bits  in  192  column word from grid for current col_idx (combinational read, valid same cycle)
- col_idx  out  3  column being fetched/displayed
- sda  out  1  DM163 serial data
- sck  out  1  DM163 shift clock
- lat  out  1  DM163 latch
- channel  out  8  one-hot column enable, active high
- frame_done  out  1  1-cycle pulse when column 7 finishes display

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Reset forces state=IDLE, col_idx=0, sda=0, sck=0, lat=0, channel=0, frame_done=0, shift register and counters 0. This applies immediately, also mid-shift; no partial frame resumes.
- IDLE: all pin outputs 0. If enable=1, go to LOAD next cycle.
- LOAD (1 cycle): capture col_bits into a 192-bit shift register; bit counter=192. Go to SHIFT.
- SHIFT, per bit, MSB first (col_bits[191] first, [0] last):
  - Low phase, SCK_DIV cycles: sck=0, sda=current MSB, set on the first cycle of the phase.
  - High phase, SCK_DIV cycles: sck=1, sda held.
  - At the end of the high phase: shift left 1, decrement counter.
  - After bit 0's high phase, go to LATCH with sck=0 and sda=0.
  - SHIFT lasts 192*2*SCK_DIV cycles (768 at default).
- LATCH: lat=1 for LAT_CYCLES cycles, sck=0. Go to DISPLAY.
- DISPLAY: channel = 1<<col_idx for ON_CYCLES cycles. On the last cycle, col_idx increments with wrap 7->0.
  - If the wrap occurs, frame_done=1 on the following cycle only.
  - Next state is LOAD if enable=1, else IDLE. col_idx is kept, so restart continues with the next column.
- channel=0 in IDLE, LOAD, SHIFT and LATCH (blanking, no ghosting).
- lat and sck are never high simultaneously. sda changes only while sck=0.
- Column period = 1 + 768 + LAT_CYCLES + ON_CYCLES clk cycles at defaults (2771).
- enable dropping mid-column has no effect until DISPLAY ends.
- col_bits changing during SHIFT (a grid write) has no effect; only the LOAD-cycle snapshot is shifted.
- Counters are sized via $clog2 of their maxima. No arithmetic overflow is possible.

Decomposition:
- Package dm163_pkg:
  - Constants: BITS_PER_PIXEL=24, PIXELS_PER_COL=8, N_COLS=8, N_BITS=192.
  - FSM state encoding: IDLE, LOAD, SHIFT, LATCH, DISPLAY.
  - Shared with the grid block.
- One sub-module, dm163_serializer:
  - Contents: shift register, bit counter and SCK phase divider.
  - Handshake: load/start in, done out.
  - The top holds the FSM, col_idx, the LAT/ON counters and channel decode.

Test Plan:
- Reset then enable=1, col_bits with [191:168]=24'hFF0000 and the rest 0:
  - first 8 sda samples on sck rising edges = 1, remaining 184 = 0;
  - exactly 192 sck rising edges; lat high 2 cycles after the last sck fall;
  - channel=8'h01 for 2000 cycles.
- Free run for 8 columns:
  - col_idx sequence 0..7 then 0;
  - channel walks 01,02,..,80; frame_done pulses exactly once per 8*2771 cycles.
- Pattern 192'hA5...A5 (alternating) at SCK_DIV=1 -> sampled sda stream equals the pattern MSB-first; sck period 2 cycles.
- Change col_bits during SHIFT -> shifted stream still equals the LOAD-cycle snapshot.
- Drop enable during SHIFT of column 3 -> column 3 completes its display, then IDLE with all outputs 0 and col_idx=4. Re-enable -> next channel asserted is 8'h10.
- Assert rst_n=0 mid-SHIFT -> sck, sda, lat and channel go to 0 with no clock edge needed; col_idx=0; after release with enable=1 the scan restarts at column 0.
